bus_arbiter_mux: RTL and testbench



---
 rtl/bus_arbiter_mux.sv | 130 +++++++++++++
 tb/tb_bus_arbiter_mux.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_mux.sv
// Registered bus source arbiter and multiplexer: picks one of NUM_SRC requesters
// (fixed priority or round-robin) and drives its word onto the bus one cycle later.
module bus_arbiter_mux #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SRC = 24,
    parameter int unsigned SEL_W   = 5,
    parameter int unsigned RR_MODE = 0
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [NUM_SRC-1:0]        req,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      hold,
    input  logic                      err_clr,
    output logic [DATA_W-1:0]         bus_out,
    output logic                      bus_valid,
    output logic [SEL_W-1:0]          grant_idx,
    output logic [NUM_SRC-1:0]        grant_onehot,
    output logic                      multi_req
);

    logic [DATA_W-1:0]  r_bus_out;
    logic               r_bus_valid;
    logic [SEL_W-1:0]   r_grant_idx;
    logic [NUM_SRC-1:0] r_grant_onehot;
    logic               r_multi_req;
    logic [SEL_W-1:0]   r_last_grant;

    logic               w_hold_cycle;
    logic               w_any_req;
    logic               w_multi;
    logic [SEL_W-1:0]   w_fp_idx;
    logic [SEL_W-1:0]   w_rr_idx;
    logic [SEL_W-1:0]   w_rr_start;
    logic [SEL_W-1:0]   w_gnt_idx;
    logic [SEL_W-1:0]   w_sel_idx;
    logic [DATA_W-1:0]  w_sel_data;
    logic [NUM_SRC-1:0] w_gnt_onehot;
    logic               w_fp_found;
    logic               w_rr_found;

    assign w_hold_cycle = hold && r_bus_valid;
    assign w_any_req    = |req;
    assign w_multi      = $countones(req) > 1;

    // Fixed priority: lowest set index wins.
    always_comb begin
        w_fp_idx   = '0;
        w_fp_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (req[i] && !w_fp_found) begin
                w_fp_idx   = SEL_W'(i);
                w_fp_found = 1'b1;
            end
        end
    end

    assign w_rr_start = (r_last_grant == SEL_W'(NUM_SRC - 1)) ? '0 : r_last_grant + 1'b1;

    // Round-robin: scan NUM_SRC positions starting just after the last grant, wrapping.
    always_comb begin
        int unsigned v_idx;
        w_rr_idx   = '0;
        w_rr_found = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            v_idx = 32'(w_rr_start) + k;
            if (v_idx >= NUM_SRC) begin
                v_idx = v_idx - NUM_SRC;
            end
            if (req[v_idx] && !w_rr_found) begin
                w_rr_idx   = SEL_W'(v_idx);
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_gnt_idx = (RR_MODE != 0) ? w_rr_idx : w_fp_idx;
    assign w_sel_idx = w_hold_cycle ? r_grant_idx : w_gnt_idx;

    always_comb begin
        w_sel_data   = '0;
        w_gnt_onehot = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (SEL_W'(i) == w_sel_idx) begin
                w_sel_data = src_data[i*DATA_W +: DATA_W];
            end
            if (SEL_W'(i) == w_gnt_idx) begin
                w_gnt_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_bus_out      <= '0;
            r_bus_valid    <= 1'b0;
            r_grant_idx    <= '0;
            r_grant_onehot <= '0;
            r_multi_req    <= 1'b0;
            r_last_grant   <= SEL_W'(NUM_SRC - 1);
        end else if (w_hold_cycle) begin
            // Live re-sample of the held source; grant, pointer and error flag frozen.
            r_bus_out <= w_sel_data;
        end else begin
            if (w_any_req) begin
                r_bus_out      <= w_sel_data;
                r_bus_valid    <= 1'b1;
                r_grant_idx    <= w_gnt_idx;
                r_grant_onehot <= w_gnt_onehot;
                r_last_grant   <= w_gnt_idx;
            end else begin
                r_bus_out      <= '0;
                r_bus_valid    <= 1'b0;
                r_grant_onehot <= '0;
            end
            if (w_multi) begin
                r_multi_req <= 1'b1;
            end else if (err_clr) begin
                r_multi_req <= 1'b0;
            end
        end
    end

    assign bus_out      = r_bus_out;
    assign bus_valid    = r_bus_valid;
    assign grant_idx    = r_grant_idx;
    assign grant_onehot = r_grant_onehot;
    assign multi_req    = r_multi_req;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: one fixed-priority and one round-robin
// instance share stimulus; expectations are hand-computed constants.
module tb_bus_arbiter_mux;

    localparam int DW = 32;
    localparam int NS = 24;
    localparam int SW = 5;

    logic              clk = 1'b0;
    logic              clr;
    logic [NS-1:0]     req;
    logic [NS*DW-1:0]  src_data;
    logic              hold;
    logic              err_clr;

    logic [DW-1:0]     fp_bus, rr_bus;
    logic              fp_valid, rr_valid;
    logic [SW-1:0]     fp_idx, rr_idx;
    logic [NS-1:0]     fp_oh, rr_oh;
    logic              fp_multi, rr_multi;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter_mux #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .RR_MODE(0)) u_fp (
        .clk(clk), .clr(clr), .req(req), .src_data(src_data), .hold(hold), .err_clr(err_clr),
        .bus_out(fp_bus), .bus_valid(fp_valid), .grant_idx(fp_idx),
        .grant_onehot(fp_oh), .multi_req(fp_multi)
    );

    bus_arbiter_mux #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .RR_MODE(1)) u_rr (
        .clk(clk), .clr(clr), .req(req), .src_data(src_data), .hold(hold), .err_clr(err_clr),
        .bus_out(rr_bus), .bus_valid(rr_valid), .grant_idx(rr_idx),
        .grant_onehot(rr_oh), .multi_req(rr_multi)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [DW-1:0] v);
        src_data[i*DW +: DW] = v;
    endtask

    task automatic chk_fp(input string tag, input logic [DW-1:0] b, input logic v,
                          input logic [SW-1:0] g, input logic [NS-1:0] oh, input logic m);
        chk({tag, ".fp.bus"},   64'(fp_bus),   64'(b));
        chk({tag, ".fp.valid"}, 64'(fp_valid), 64'(v));
        chk({tag, ".fp.idx"},   64'(fp_idx),   64'(g));
        chk({tag, ".fp.oh"},    64'(fp_oh),    64'(oh));
        chk({tag, ".fp.multi"}, 64'(fp_multi), 64'(m));
    endtask

    task automatic chk_rr(input string tag, input logic [DW-1:0] b, input logic v,
                          input logic [SW-1:0] g, input logic [NS-1:0] oh, input logic m);
        chk({tag, ".rr.bus"},   64'(rr_bus),   64'(b));
        chk({tag, ".rr.valid"}, 64'(rr_valid), 64'(v));
        chk({tag, ".rr.idx"},   64'(rr_idx),   64'(g));
        chk({tag, ".rr.oh"},    64'(rr_oh),    64'(oh));
        chk({tag, ".rr.multi"}, 64'(rr_multi), 64'(m));
    endtask

    initial begin
        clr = 1'b0; req = '0; hold = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < NS; i++) set_src(i, 32'(100 + i));
        set_src(0, 240); set_src(1, 2); set_src(2, 1235); set_src(4, 10);
        set_src(5, 530); set_src(23, 2300);

        // Reset and idle
        step(); step();
        chk_fp("reset", 0, 0, 0, 0, 0);
        chk_rr("reset", 0, 0, 0, 0, 0);
        clr = 1'b1;
        step();
        chk_fp("idle", 0, 0, 0, 0, 0);

        // Single source
        req = 24'h000004;
        step();
        chk_fp("single", 1235, 1, 2, 24'h000004, 0);
        chk_rr("single", 1235, 1, 2, 24'h000004, 0);

        // Priority vs round-robin with multiple requests (rr last=2 -> search from 3)
        req = 24'h000032;
        step();
        chk_fp("prio", 2, 1, 1, 24'h000002, 1);
        chk_rr("prio", 10, 1, 4, 24'h000010, 1);

        // err_clr with a lone requester; rr lone requester equals last_grant
        err_clr = 1'b1; req = 24'h000010;
        step();
        chk_fp("errclr", 10, 1, 4, 24'h000010, 0);
        chk_rr("errclr", 10, 1, 4, 24'h000010, 0);

        // set wins over err_clr; rr wraps from 5 to 0
        req = 24'h000011;
        step();
        chk_fp("setwins", 240, 1, 0, 24'h000001, 1);
        chk_rr("setwins", 240, 1, 0, 24'h000001, 1);

        // Round-robin wrap from a fresh reset
        err_clr = 1'b0; req = '0; clr = 1'b0;
        step();
        chk_rr("rst2", 0, 0, 0, 0, 0);
        clr = 1'b1; req = 24'h800001;
        step(); chk("wrap0.rr.idx", 64'(rr_idx), 0);  chk("wrap0.fp.idx", 64'(fp_idx), 0);
        step(); chk("wrap1.rr.idx", 64'(rr_idx), 23); chk("wrap1.rr.bus", 64'(rr_bus), 2300);
        step(); chk("wrap2.rr.idx", 64'(rr_idx), 0);  chk("wrap2.fp.idx", 64'(fp_idx), 0);
        step(); chk("wrap3.rr.idx", 64'(rr_idx), 23); chk("wrap3.rr.oh", 64'(rr_oh), 64'h800000);

        // Grant source 5 and clear the error flag
        req = 24'h000020; err_clr = 1'b1;
        step();
        chk_fp("g5", 530, 1, 5, 24'h000020, 0);
        chk_rr("g5", 530, 1, 5, 24'h000020, 0);

        // No request: grant_idx keeps its old value
        err_clr = 1'b0; req = '0;
        step();
        chk_fp("noreq", 0, 0, 5, 0, 0);
        chk_rr("noreq", 0, 0, 5, 0, 0);

        // hold with bus_valid=0 is an ordinary arbitration
        hold = 1'b1; req = 24'h000008;
        step();
        chk_fp("holdinv", 103, 1, 3, 24'h000008, 0);
        chk_rr("holdinv", 103, 1, 3, 24'h000008, 0);

        // Regrant 5, then hold with live data changes
        hold = 1'b0; req = 24'h000020;
        step();
        chk_fp("g5b", 530, 1, 5, 24'h000020, 0);
        hold = 1'b1; req = 24'h000001; set_src(5, 77);
        step();
        chk_fp("hold1", 77, 1, 5, 24'h000020, 0);
        chk_rr("hold1", 77, 1, 5, 24'h000020, 0);
        req = 24'h000003; set_src(5, 78);
        step();
        chk_fp("hold2", 78, 1, 5, 24'h000020, 0);
        chk_rr("hold2", 78, 1, 5, 24'h000020, 0);
        req = 24'h000000; set_src(5, 79);
        step();
        chk_fp("hold3", 79, 1, 5, 24'h000020, 0);

        // Drop hold
        hold = 1'b0; req = 24'h000001;
        step();
        chk_fp("unhold", 240, 1, 0, 24'h000001, 0);
        chk_rr("unhold", 240, 1, 0, 24'h000001, 0);

        // Reset in the middle of a hold
        req = 24'h000020;
        step();
        chk("g5c.fp.idx", 64'(fp_idx), 5);
        hold = 1'b1; clr = 1'b0;
        step();
        chk_fp("rsthold", 0, 0, 0, 0, 0);
        chk_rr("rsthold", 0, 0, 0, 0, 0);

        // RR pointer restarts at 0
        clr = 1'b1; hold = 1'b0; req = 24'hFFFFFF;
        step();
        chk_rr("allreq0", 240, 1, 0, 24'h000001, 1);
        chk_fp("allreq0", 240, 1, 0, 24'h000001, 1);
        step();
        chk_rr("allreq1", 2, 1, 1, 24'h000002, 1);
        chk("allreq1.fp.idx", 64'(fp_idx), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
